aexm_ifetch: RTL and testbench

// Instruction fetch front end. It supplies the instruction word consumed by the decode-side instruction buffer.
// - Owns the fetch PC and issues word reads on a classic Wishbone instruction bus (IWB).
// - Queues returned words with their PCs.
// - Presents the head word to decode on aexm_icache_datai and advances on d_en.
// - Flushes and redirects on a taken branch.

---
 rtl/aexm_pkg.sv | 18 +
 rtl/aexm_ififo.sv | 51 +++++
 rtl/aexm_ifetch.sv | 126 ++++++++++++
 tb/tb_aexm_ifetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aexm_pkg.sv
// Shared constants and fetch-state encoding for the AEXM instruction fetch path.
package aexm_pkg;

  // Word presented to decode when no fetched instruction is available.
  localparam logic [31:0] AEXM_NOP = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  // Next sequential word address; wraps naturally at the top of the space.
  function automatic logic [29:0] next_word(input logic [29:0] adr);
    return adr + 30'd1;
  endfunction

endpackage

// File: rtl/aexm_ififo.sv
// Fetch queue: DEPTH entries of {pc, instruction}. Flush beats push and pop.
module aexm_ififo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [63:0]   i_data,
  output logic [63:0]   o_head,
  output logic [AW:0]   o_count,
  output logic          o_empty
);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic          w_wr_en;

  assign w_wr_en = i_push && !i_flush && !grst;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge gclk) begin
    if (w_wr_en) r_mem[r_wr] <= i_data;
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge gclk) begin
    if (grst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/aexm_ifetch.sv
// Instruction fetch front end: owns the fetch PC, issues Wishbone classic
// word reads, queues returned words and presents the head word to decode.
//
// state   | meaning
// IDLE    | no bus cycle; waiting for a free queue credit
// REQ     | strobe high at the fetch PC; ack pushes the word
// DISCARD | strobe held on a stale address after a redirect; ack is dropped
module aexm_ifetch
  import aexm_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        d_en,
  input  logic        rBRA,
  input  logic [31:0] rBRA_ADR,
  output logic [29:0] iwb_adr_o,
  output logic        iwb_stb_o,
  input  logic        iwb_ack_i,
  input  logic [31:0] iwb_dat_i,
  output logic [31:0] aexm_icache_datai,
  output logic [31:0] rIPC,
  output logic        fEMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  fetch_state_t r_state, w_state_nxt;
  logic [29:0]  r_pc, w_pc_nxt;
  logic [29:0]  r_stale, w_stale_nxt;
  logic [31:0]  r_ipc_hold;

  logic [63:0]  w_head;
  logic [AW:0]  w_count;
  logic         w_empty;
  logic         w_outstanding;
  logic         w_credit;
  logic         w_room_after;
  logic         w_push;
  logic         w_pop;
  logic [31:0]  w_bra_pc;

  assign w_bra_pc      = rBRA_ADR & 32'hFFFF_FFFC;
  assign w_outstanding = (r_state != ST_IDLE);
  assign w_push        = (r_state == ST_REQ) && iwb_ack_i && !rBRA;
  assign w_pop         = d_en && !w_empty && !rBRA;

  // Credits count the outstanding request as already occupying a slot,
  // so an ack can never arrive at a full queue.
  assign w_credit     = (CW'(w_count) + CW'(w_outstanding)) < CW'(DEPTH);
  assign w_room_after = (CW'(w_count) + CW'(w_push) - CW'(w_pop)) < CW'(DEPTH);

  aexm_ififo #(.DEPTH(DEPTH)) u_ififo (
    .gclk    (gclk),
    .grst    (grst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (rBRA),
    .i_data  ({r_pc, 2'b00, iwb_dat_i}),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // State, fetch PC, stale bus address and empty-queue PC registers.
  always_ff @(posedge gclk) begin
    if (grst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC[31:2];
      r_stale    <= RESET_PC[31:2];
      r_ipc_hold <= {RESET_PC[31:2], 2'b00};
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_stale <= w_stale_nxt;
      if (rBRA)       r_ipc_hold <= w_bra_pc;
      else if (w_pop) r_ipc_hold <= w_head[63:32] + 32'd4;
    end
  end

  // Next-state, fetch PC update and bus/decode outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_stale_nxt = r_stale;

    case (r_state)
      ST_IDLE: begin
        if (rBRA) begin
          w_pc_nxt    = w_bra_pc[31:2];
          w_state_nxt = ST_REQ;
        end else if (w_credit) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (rBRA) begin
          w_pc_nxt = w_bra_pc[31:2];
          // Without an ack the bus cycle must finish on the old address.
          if (!iwb_ack_i) begin
            w_stale_nxt = r_pc;
            w_state_nxt = ST_DISCARD;
          end
        end else if (iwb_ack_i) begin
          w_pc_nxt    = next_word(r_pc);
          w_state_nxt = w_room_after ? ST_REQ : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (rBRA) w_pc_nxt = w_bra_pc[31:2];
        if (iwb_ack_i) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    iwb_stb_o         = w_outstanding;
    iwb_adr_o         = (r_state == ST_DISCARD) ? r_stale : r_pc;
    fEMPTY            = w_empty;
    aexm_icache_datai = w_empty ? AEXM_NOP : w_head[31:0];
    rIPC              = w_empty ? r_ipc_hold : w_head[63:32];
  end

endmodule

// File: tb/tb_aexm_ifetch.sv
// Directed bench for aexm_ifetch: streaming, fill/credits, redirects,
// address wrap and reset during an outstanding request.
module tb_aexm_ifetch;

  logic        gclk = 1'b0;
  logic        grst;
  logic        d_en;
  logic        rBRA;
  logic [31:0] rBRA_ADR;
  logic [29:0] iwb_adr_o;
  logic        iwb_stb_o;
  logic        iwb_ack_i;
  logic [31:0] iwb_dat_i;
  logic [31:0] aexm_icache_datai;
  logic [31:0] rIPC;
  logic        fEMPTY;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h8000_0000;

  aexm_ifetch #(.DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
    .gclk              (gclk),
    .grst              (grst),
    .d_en              (d_en),
    .rBRA              (rBRA),
    .rBRA_ADR          (rBRA_ADR),
    .iwb_adr_o         (iwb_adr_o),
    .iwb_stb_o         (iwb_stb_o),
    .iwb_ack_i         (iwb_ack_i),
    .iwb_dat_i         (iwb_dat_i),
    .aexm_icache_datai (aexm_icache_datai),
    .rIPC              (rIPC),
    .fEMPTY            (fEMPTY)
  );

  always #5 gclk = ~gclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h1357_9BDF;
  endfunction

  // One clock: inputs take effect at the posedge, outputs are sampled at the negedge.
  task automatic step();
    @(posedge gclk);
    @(negedge gclk);
  endtask

  // Memory slave: zero-wait ack when enabled, data from the current address.
  task automatic bus_drive(input logic en);
    iwb_ack_i = en & iwb_stb_o;
    iwb_dat_i = mem_word(iwb_adr_o);
  endtask

  task automatic do_reset();
    grst = 1'b1; d_en = 1'b0; rBRA = 1'b0; rBRA_ADR = 32'h0;
    iwb_ack_i = 1'b0; iwb_dat_i = 32'h0;
    step();
    step();
    grst = 1'b0;
  endtask

  task automatic test_reset();
    grst = 1'b1; d_en = 1'b0; rBRA = 1'b0; rBRA_ADR = 32'h0;
    iwb_ack_i = 1'b0; iwb_dat_i = 32'h0;
    step();
    step();
    checks++; if (iwb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %0b want 0", iwb_stb_o); end
    checks++; if (iwb_adr_o !== 30'h40) begin errors++; $display("FAIL reset_adr: got %h want 40", iwb_adr_o); end
    checks++; if (fEMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", fEMPTY); end
    checks++; if (aexm_icache_datai !== NOP) begin errors++; $display("FAIL reset_datai: got %h want %h", aexm_icache_datai, NOP); end
    checks++; if (rIPC !== 32'h100) begin errors++; $display("FAIL reset_ipc: got %h want 100", rIPC); end
    grst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    int pops;
    do_reset();
    exp_pc = 32'h100;
    pops = 0;
    d_en = 1'b1;
    bus_drive(1'b1);
    for (int n = 1; n <= 16; n++) begin
      step();
      checks++;
      if (fEMPTY !== logic'(n < 2)) begin
        errors++; $display("FAIL stream_empty n=%0d: got %0b want %0b", n, fEMPTY, logic'(n < 2));
      end
      if (!fEMPTY) begin
        checks++;
        if (rIPC !== exp_pc) begin errors++; $display("FAIL stream_ipc n=%0d: got %h want %h", n, rIPC, exp_pc); end
        checks++;
        if (aexm_icache_datai !== mem_word(exp_pc[31:2])) begin
          errors++; $display("FAIL stream_data n=%0d: got %h want %h", n, aexm_icache_datai, mem_word(exp_pc[31:2]));
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      bus_drive(1'b1);
    end
    checks++; if (pops != 15) begin errors++; $display("FAIL stream_pops: got %0d want 15", pops); end
    d_en = 1'b0; iwb_ack_i = 1'b0;
  endtask

  task automatic test_fill();
    int acks;
    do_reset();
    acks = 0;
    bus_drive(1'b1);
    for (int n = 1; n <= 12; n++) begin
      step();
      bus_drive(1'b1);
      if (iwb_ack_i) acks++;
    end
    checks++; if (acks != 4) begin errors++; $display("FAIL fill_acks: got %0d want 4", acks); end
    checks++; if (iwb_stb_o !== 1'b0) begin errors++; $display("FAIL fill_stb: got %0b want 0", iwb_stb_o); end
    checks++; if (fEMPTY !== 1'b0) begin errors++; $display("FAIL fill_empty: got %0b want 0", fEMPTY); end
    checks++; if (rIPC !== 32'h100) begin errors++; $display("FAIL fill_head: got %h want 100", rIPC); end
    d_en = 1'b1;
    step();
    d_en = 1'b0;
    checks++; if (rIPC !== 32'h104) begin errors++; $display("FAIL fill_pop_head: got %h want 104", rIPC); end
    acks = 0;
    bus_drive(1'b1);
    if (iwb_ack_i) acks++;
    for (int n = 1; n <= 8; n++) begin
      step();
      bus_drive(1'b1);
      if (iwb_ack_i) acks++;
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL fill_refill_acks: got %0d want 1", acks); end
    checks++; if (iwb_stb_o !== 1'b0) begin errors++; $display("FAIL fill_refill_stb: got %0b want 0", iwb_stb_o); end
    iwb_ack_i = 1'b0;
  endtask

  task automatic test_discard();
    do_reset();
    step();
    checks++; if (iwb_stb_o !== 1'b1) begin errors++; $display("FAIL disc_stb0: got %0b want 1", iwb_stb_o); end
    iwb_ack_i = 1'b0;
    rBRA = 1'b1; rBRA_ADR = 32'h0000_2002;
    step();
    rBRA = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (iwb_stb_o !== 1'b1 || iwb_adr_o !== 30'h40) begin
        errors++; $display("FAIL disc_hold n=%0d: got stb=%0b adr=%h want stb=1 adr=40", n, iwb_stb_o, iwb_adr_o);
      end
      checks++;
      if (fEMPTY !== 1'b1 || rIPC !== 32'h2000) begin
        errors++; $display("FAIL disc_head n=%0d: got empty=%0b ipc=%h want empty=1 ipc=2000", n, fEMPTY, rIPC);
      end
      step();
    end
    iwb_ack_i = 1'b1; iwb_dat_i = 32'hDEAD_BEEF;
    step();
    iwb_ack_i = 1'b0;
    checks++; if (iwb_stb_o !== 1'b1 || iwb_adr_o !== 30'h800) begin
      errors++; $display("FAIL disc_new_req: got stb=%0b adr=%h want stb=1 adr=800", iwb_stb_o, iwb_adr_o);
    end
    checks++; if (fEMPTY !== 1'b1) begin errors++; $display("FAIL disc_dropped: got empty=%0b want 1", fEMPTY); end
    bus_drive(1'b1);
    step();
    iwb_ack_i = 1'b0;
    checks++; if (fEMPTY !== 1'b0 || rIPC !== 32'h2000) begin
      errors++; $display("FAIL disc_target_head: got empty=%0b ipc=%h want empty=0 ipc=2000", fEMPTY, rIPC);
    end
    checks++; if (aexm_icache_datai !== mem_word(30'h800)) begin
      errors++; $display("FAIL disc_target_data: got %h want %h", aexm_icache_datai, mem_word(30'h800));
    end
  endtask

  task automatic test_bra_ack();
    do_reset();
    step();
    bus_drive(1'b1);
    step();
    bus_drive(1'b1);
    step();
    checks++; if (iwb_adr_o !== 30'h42) begin errors++; $display("FAIL braack_adr: got %h want 42", iwb_adr_o); end
    bus_drive(1'b1);
    rBRA = 1'b1; rBRA_ADR = 32'h0000_3000;
    step();
    rBRA = 1'b0;
    checks++; if (iwb_stb_o !== 1'b1 || iwb_adr_o !== 30'hC00) begin
      errors++; $display("FAIL braack_req: got stb=%0b adr=%h want stb=1 adr=c00", iwb_stb_o, iwb_adr_o);
    end
    checks++; if (fEMPTY !== 1'b1 || rIPC !== 32'h3000) begin
      errors++; $display("FAIL braack_flush: got empty=%0b ipc=%h want empty=1 ipc=3000", fEMPTY, rIPC);
    end
    bus_drive(1'b1);
    step();
    checks++; if (fEMPTY !== 1'b0 || rIPC !== 32'h3000 || aexm_icache_datai !== mem_word(30'hC00)) begin
      errors++; $display("FAIL braack_head: got empty=%0b ipc=%h data=%h want empty=0 ipc=3000 data=%h",
                         fEMPTY, rIPC, aexm_icache_datai, mem_word(30'hC00));
    end
    d_en = 1'b1;
    bus_drive(1'b1);
    step();
    d_en = 1'b0; iwb_ack_i = 1'b0;
    checks++; if (rIPC !== 32'h3004) begin errors++; $display("FAIL braack_next: got %h want 3004", rIPC); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    do_reset();
    step();
    bus_drive(1'b1);
    rBRA = 1'b1; rBRA_ADR = 32'hFFFF_FFF8;
    step();
    rBRA = 1'b0;
    for (int n = 0; n < 3; n++) begin
      bus_drive(1'b1);
      step();
    end
    iwb_ack_i = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (fEMPTY !== 1'b0 || rIPC !== exp_pc || aexm_icache_datai !== mem_word(exp_pc[31:2])) begin
        errors++; $display("FAIL wrap_head n=%0d: got empty=%0b ipc=%h data=%h want ipc=%h data=%h",
                           n, fEMPTY, rIPC, aexm_icache_datai, exp_pc, mem_word(exp_pc[31:2]));
      end
      exp_pc = exp_pc + 32'd4;
      d_en = 1'b1;
      step();
    end
    d_en = 1'b0;
    checks++; if (fEMPTY !== 1'b1 || rIPC !== 32'h4) begin
      errors++; $display("FAIL wrap_hold: got empty=%0b ipc=%h want empty=1 ipc=4", fEMPTY, rIPC);
    end
    checks++; if (iwb_adr_o !== 30'h1) begin errors++; $display("FAIL wrap_fetch_adr: got %h want 1", iwb_adr_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    checks++; if (iwb_stb_o !== 1'b1) begin errors++; $display("FAIL rstmid_stb_pre: got %0b want 1", iwb_stb_o); end
    iwb_ack_i = 1'b0;
    grst = 1'b1;
    step();
    checks++; if (iwb_stb_o !== 1'b0 || iwb_adr_o !== 30'h40) begin
      errors++; $display("FAIL rstmid_bus: got stb=%0b adr=%h want stb=0 adr=40", iwb_stb_o, iwb_adr_o);
    end
    checks++; if (fEMPTY !== 1'b1 || aexm_icache_datai !== NOP || rIPC !== 32'h100) begin
      errors++; $display("FAIL rstmid_head: got empty=%0b data=%h ipc=%h want empty=1 data=%h ipc=100",
                         fEMPTY, aexm_icache_datai, rIPC, NOP);
    end
    grst = 1'b0;
    iwb_ack_i = 1'b1; iwb_dat_i = 32'hBAD0_0BAD;
    step();
    iwb_ack_i = 1'b0;
    checks++; if (fEMPTY !== 1'b1) begin errors++; $display("FAIL rstmid_stray_ack: got empty=%0b want 1", fEMPTY); end
  endtask

  initial begin
    grst = 1'b1; d_en = 1'b0; rBRA = 1'b0; rBRA_ADR = 32'h0;
    iwb_ack_i = 1'b0; iwb_dat_i = 32'h0;
    @(negedge gclk);
    test_reset();
    test_stream();
    test_fill();
    test_discard();
    test_bra_ack();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
